// File: rtl/dcache_if.sv
// Bundles the CPU load/store port, the flush handshake and the block-wide memory port
// of the data cache controller.
interface dcache_if #(
   parameter int WORD_SIZE  = 32,
   parameter int BLOCK_SIZE = 128
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [WORD_SIZE-1:0]  cpu_addr;
   logic [WORD_SIZE-1:0]  cpu_wdata;
   logic [WORD_SIZE-1:0]  cpu_rdata;
   logic                  cpu_ready;
   logic                  cpu_stall;
   logic                  flush_req;
   logic                  flush_done;
   logic [WORD_SIZE-1:0]  mem_addr;
   logic                  mem_readable;
   logic                  mem_writable;
   logic [BLOCK_SIZE-1:0] mem_write;
   logic [BLOCK_SIZE-1:0] mem_out;
   logic                  mem_flush;

   // cache side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_out,
      output cpu_rdata, cpu_ready, cpu_stall, flush_done,
      output mem_addr, mem_readable, mem_writable, mem_write, mem_flush
   );

   // CPU plus memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_out,
      input  cpu_rdata, cpu_ready, cpu_stall, flush_done,
      input  mem_addr, mem_readable, mem_writable, mem_write, mem_flush
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between a word-wide CPU port
// and a block-wide data memory, with a scan-and-write-back flush.
module dcache_ctrl #(
   parameter int WORD_SIZE  = 32,
   parameter int BLOCK_SIZE = 128,
   parameter int LINES      = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   dcache_if.slave  bus
);
   localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
   localparam int WORDS  = BLOCK_SIZE / WORD_SIZE;
   localparam int WSEL_W = $clog2(WORDS);

   typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_REFILL, S_FLUSH, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [LINES-1:0]       valid_q, dirty_q;
   logic [TAG_W-1:0]       tag_arr  [LINES];
   logic [BLOCK_SIZE-1:0]  data_arr [LINES];
   logic                   req_we_q, from_flush_q, ready_q, mem_flush_q;
   logic [WORD_SIZE-1:0]   req_addr_q, req_wdata_q, rdata_q;
   logic [IDX_W-1:0]       flush_idx_q;

   // Lowest-addressed word sits in the most significant lane of a block.
   function automatic logic [WORD_SIZE-1:0] get_word(input logic [BLOCK_SIZE-1:0] blk,
                                                      input logic [WSEL_W-1:0] sel);
      logic [WORD_SIZE-1:0] w;
      w = '0;
      for (int k = 0; k < WORDS; k++)
         if (sel == WSEL_W'(k)) w = blk[BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE];
      return w;
   endfunction

   function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] blk,
                                                       input logic [WSEL_W-1:0] sel,
                                                       input logic [WORD_SIZE-1:0] w);
      logic [BLOCK_SIZE-1:0] r;
      r = blk;
      for (int k = 0; k < WORDS; k++)
         if (sel == WSEL_W'(k)) r[BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE] = w;
      return r;
   endfunction

   logic [IDX_W-1:0]      in_idx, req_idx, vic_idx;
   logic [TAG_W-1:0]      in_tag, req_tag;
   logic [WSEL_W-1:0]     in_sel, req_sel;
   logic                  accept, take_cpu, take_flush, in_hit, flush_line_dirty, last_idx;
   logic [BLOCK_SIZE-1:0] hit_blk, refill_blk;

   assign in_idx  = bus.cpu_addr[OFF_W +: IDX_W];
   assign in_tag  = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
   assign in_sel  = bus.cpu_addr[OFF_W-1 -: WSEL_W];
   assign req_idx = req_addr_q[OFF_W +: IDX_W];
   assign req_tag = req_addr_q[WORD_SIZE-1 -: TAG_W];
   assign req_sel = req_addr_q[OFF_W-1 -: WSEL_W];

   // The completion cycle is skipped so a request still held while cpu_ready is
   // high is not taken a second time.
   assign accept     = (state_q == S_IDLE) && !ready_q;
   assign take_cpu   = accept && bus.cpu_req;
   assign take_flush = accept && !bus.cpu_req && bus.flush_req;
   assign in_hit     = valid_q[in_idx] && (tag_arr[in_idx] == in_tag);

   assign vic_idx          = from_flush_q ? flush_idx_q : req_idx;
   assign flush_line_dirty = valid_q[flush_idx_q] && dirty_q[flush_idx_q];
   assign last_idx         = (flush_idx_q == IDX_W'(LINES - 1));

   assign hit_blk    = bus.cpu_we ? put_word(data_arr[in_idx], in_sel, bus.cpu_wdata)
                                  : data_arr[in_idx];
   assign refill_blk = req_we_q ? put_word(bus.mem_out, req_sel, req_wdata_q) : bus.mem_out;

   wire unused_addr_bits = &{1'b0, bus.cpu_addr[OFF_W-WSEL_W-1:0],
                             req_addr_q[OFF_W-WSEL_W-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (take_cpu && !in_hit)
               state_d = (valid_q[in_idx] && dirty_q[in_idx]) ? S_WB : S_FILL;
            else if (take_flush)
               state_d = S_FLUSH;
         end
         S_WB: begin
            if (!from_flush_q) state_d = S_FILL;
            else if (last_idx) state_d = S_DONE;
            else               state_d = S_FLUSH;
         end
         S_FILL:   state_d = S_REFILL;
         S_REFILL: state_d = S_IDLE;
         S_FLUSH: begin
            if (flush_line_dirty) state_d = S_WB;
            else if (last_idx)    state_d = S_DONE;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cpu_stall    = (state_q != S_IDLE);
      bus.cpu_ready    = ready_q;
      bus.cpu_rdata    = ready_q ? rdata_q : '0;
      bus.flush_done   = (state_q == S_DONE);
      bus.mem_flush    = mem_flush_q;
      bus.mem_readable = 1'b0;
      bus.mem_writable = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_write    = '0;
      case (state_q)
         S_WB: begin
            bus.mem_writable = 1'b1;
            bus.mem_addr     = {tag_arr[vic_idx], vic_idx, {OFF_W{1'b0}}};
            bus.mem_write    = data_arr[vic_idx];
         end
         S_FILL: begin
            bus.mem_readable = 1'b1;
            bus.mem_addr     = {req_tag, req_idx, {OFF_W{1'b0}}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= '0;
         dirty_q      <= '0;
         req_we_q     <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         from_flush_q <= 1'b0;
         flush_idx_q  <= '0;
         ready_q      <= 1'b0;
         rdata_q      <= '0;
         mem_flush_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (take_cpu) begin
            req_we_q     <= bus.cpu_we;
            req_addr_q   <= bus.cpu_addr;
            req_wdata_q  <= bus.cpu_wdata;
            from_flush_q <= 1'b0;
            if (in_hit) begin
               ready_q <= 1'b1;
               rdata_q <= get_word(hit_blk, in_sel);
               if (bus.cpu_we) dirty_q[in_idx] <= 1'b1;
            end
         end
         if (take_flush) begin
            from_flush_q <= 1'b1;
            flush_idx_q  <= '0;
         end
         case (state_q)
            S_WB: begin
               if (from_flush_q) begin
                  dirty_q[flush_idx_q] <= 1'b0;
                  flush_idx_q          <= flush_idx_q + 1'b1;
               end
            end
            S_FLUSH: if (!flush_line_dirty) flush_idx_q <= flush_idx_q + 1'b1;
            S_REFILL: begin
               valid_q[req_idx] <= 1'b1;
               dirty_q[req_idx] <= req_we_q;
               ready_q          <= 1'b1;
               rdata_q          <= get_word(refill_blk, req_sel);
            end
            default: ;
         endcase
         if (state_d == S_DONE) mem_flush_q <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; valid bits alone decide whether they count.
   always_ff @(posedge clk) begin
      if (take_cpu && in_hit && bus.cpu_we) data_arr[in_idx] <= hit_blk;
      if (state_q == S_REFILL) begin
         data_arr[req_idx] <= refill_blk;
         tag_arr[req_idx]  <= req_tag;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, misses, dirty eviction, flush, reset and
// request priority, against a behavioural block memory.
module tb_dcache_ctrl;
   localparam int WS = 32;
   localparam int BS = 128;
   localparam int LN = 16;

   localparam logic [BS-1:0] B10  = 128'h11111111_22222222_33333333_44444444;
   localparam logic [BS-1:0] B20  = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
   localparam logic [BS-1:0] B110 = 128'h55555555_66666666_77777777_88888888;
   localparam logic [BS-1:0] BF0  = 128'hF1F1F1F1_F2F2F2F2_F3F3F3F3_F4F4F4F4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) bus ();

   dcache_ctrl #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .LINES(LN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Block memory: preset contents, overridden by whatever the cache writes back.
   logic [BS-1:0] wmem [int];
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   logic [WS-1:0] rd_addr_log [$];
   logic [WS-1:0] wr_addr_log [$];
   logic [BS-1:0] wr_data_log [$];

   function automatic logic [BS-1:0] init_block(input logic [WS-1:0] a);
      case (a)
         32'h10:  return B10;
         32'h20:  return B20;
         32'h110: return B110;
         32'hF0:  return BF0;
         default: return {4{a}};
      endcase
   endfunction

   function automatic logic [BS-1:0] rd_block(input logic [WS-1:0] a);
      if (wmem.exists(int'(a))) return wmem[int'(a)];
      return init_block(a);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_readable) begin
         bus.mem_out <= rd_block(bus.mem_addr);
         rd_cnt++;
         rd_addr_log.push_back(bus.mem_addr);
      end
      if (bus.mem_writable) begin
         wmem[int'(bus.mem_addr)] = bus.mem_write;
         wr_cnt++;
         wr_addr_log.push_back(bus.mem_addr);
         wr_data_log.push_back(bus.mem_write);
      end
      if (bus.mem_readable && bus.mem_writable) both_cnt++;
   end

   // One idle edge, then a request held until cpu_ready (bounded).
   task automatic access(input logic we, input logic [WS-1:0] addr, input logic [WS-1:0] wd,
                         output int lat, output logic [WS-1:0] rdata, output int rds,
                         output int wrs, output logic rd0, output logic [WS-1:0] addr0);
      int r0, w0;
      @(posedge clk); #1;
      rd_addr_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      r0 = rd_cnt;
      w0 = wr_cnt;
      bus.cpu_req = 1'b1;
      bus.cpu_we = we;
      bus.cpu_addr = addr;
      bus.cpu_wdata = wd;
      lat = 0;
      rd0 = 1'b0;
      addr0 = '0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            rd0 = bus.mem_readable;
            addr0 = bus.mem_addr;
         end
      end while (!bus.cpu_ready && lat < 40);
      rdata = bus.cpu_rdata;
      bus.cpu_req = 1'b0;
      rds = rd_cnt - r0;
      wrs = wr_cnt - w0;
      $display("access we=%0d addr=%08h wdata=%08h -> lat=%0d rdata=%08h rd=%0d wr=%0d",
               we, addr, wd, lat, rdata, rds, wrs);
   endtask

   task automatic test_reset();
      logic [WS-1:0] outs;
      repeat (2) @(posedge clk);
      #1;
      outs = {bus.cpu_ready, bus.cpu_stall, bus.mem_readable, bus.mem_writable,
              bus.mem_flush, bus.flush_done};
      n_cmp++;
      if (outs !== '0 || bus.mem_addr !== '0 || bus.cpu_rdata !== '0 || bus.mem_write !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: flags=%0h addr=%08h rdata=%08h, required all zero",
                  outs, bus.mem_addr, bus.cpu_rdata);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset released");
   endtask

   task automatic test_load_miss_hit();
      int lat, rds, wrs; logic rd0; logic [WS-1:0] rdata, addr0;
      access(1'b0, 32'h10, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 3 || rdata !== 32'h11111111) begin
         n_bad++;
         $display("FAIL load_miss: lat=%0d rdata=%08h, required lat=3 rdata=11111111", lat, rdata);
      end
      n_cmp++;
      if (rd0 !== 1'b1 || addr0 !== 32'h10 || rds !== 1 || wrs !== 0) begin
         n_bad++;
         $display("FAIL load_miss_fill: rd0=%0d addr=%08h rd=%0d wr=%0d, required 1 00000010 1 0",
                  rd0, addr0, rds, wrs);
      end
      access(1'b0, 32'h10, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 1 || rdata !== 32'h11111111 || rds !== 0 || wrs !== 0) begin
         n_bad++;
         $display("FAIL load_hit: lat=%0d rdata=%08h rd=%0d wr=%0d, required 1 11111111 0 0",
                  lat, rdata, rds, wrs);
      end
   endtask

   task automatic test_store_hit();
      int lat, rds, wrs; logic rd0; logic [WS-1:0] rdata, addr0;
      access(1'b1, 32'h18, 32'hDEADBEEF, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 1 || rds !== 0 || wrs !== 0) begin
         n_bad++;
         $display("FAIL store_hit: lat=%0d rd=%0d wr=%0d, required 1 0 0", lat, rds, wrs);
      end
      access(1'b0, 32'h18, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 1 || rdata !== 32'hDEADBEEF || wrs !== 0) begin
         n_bad++;
         $display("FAIL store_readback: lat=%0d rdata=%08h wr=%0d, required 1 DEADBEEF 0",
                  lat, rdata, wrs);
      end
   endtask

   task automatic test_dirty_evict();
      int lat, rds, wrs; logic rd0; logic [WS-1:0] rdata, addr0;
      access(1'b0, 32'h118, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 4 || rdata !== 32'h77777777 || rds !== 1 || wrs !== 1) begin
         n_bad++;
         $display("FAIL evict_load: lat=%0d rdata=%08h rd=%0d wr=%0d, required 4 77777777 1 1",
                  lat, rdata, rds, wrs);
      end
      n_cmp++;
      if (rd0 !== 1'b0 || addr0 !== 32'h10) begin
         n_bad++;
         $display("FAIL evict_wb_first: rd0=%0d addr=%08h, required 0 00000010", rd0, addr0);
      end
      n_cmp++;
      if (wr_addr_log.size() != 1 || rd_addr_log.size() != 1) begin
         n_bad++;
         $display("FAIL evict_logs: writes=%0d reads=%0d, required 1 1",
                  wr_addr_log.size(), rd_addr_log.size());
      end else begin
         if (wr_addr_log[0] !== 32'h10 || rd_addr_log[0] !== 32'h110 ||
             wr_data_log[0] !== 128'h11111111_22222222_DEADBEEF_44444444) begin
            n_bad++;
            $display("FAIL evict_data: wa=%08h ra=%08h wd=%032h, required 00000010 00000110 %032h",
                     wr_addr_log[0], rd_addr_log[0], wr_data_log[0],
                     128'h11111111_22222222_DEADBEEF_44444444);
         end
      end
      access(1'b0, 32'h110, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 1 || rdata !== 32'h55555555) begin
         n_bad++;
         $display("FAIL evict_installed: lat=%0d rdata=%08h, required 1 55555555", lat, rdata);
      end
   endtask

   task automatic test_store_miss();
      int lat, rds, wrs; logic rd0; logic [WS-1:0] rdata, addr0;
      access(1'b1, 32'h24, 32'hCAFEF00D, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 3 || rds !== 1 || wrs !== 0 || addr0 !== 32'h20) begin
         n_bad++;
         $display("FAIL store_miss: lat=%0d rd=%0d wr=%0d addr=%08h, required 3 1 0 00000020",
                  lat, rds, wrs, addr0);
      end
      access(1'b0, 32'h24, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 1 || rdata !== 32'hCAFEF00D) begin
         n_bad++;
         $display("FAIL store_miss_word1: lat=%0d rdata=%08h, required 1 CAFEF00D", lat, rdata);
      end
      access(1'b0, 32'h20, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 1 || rdata !== 32'hA0A0A0A0) begin
         n_bad++;
         $display("FAIL store_miss_word0: lat=%0d rdata=%08h, required 1 A0A0A0A0", lat, rdata);
      end
      access(1'b1, 32'hF0, 32'h0F0F0F0F, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 3 || wrs !== 0) begin
         n_bad++;
         $display("FAIL store_miss_line15: lat=%0d wr=%0d, required 3 0", lat, wrs);
      end
   endtask

   task automatic test_flush();
      int n, w0;
      logic seen;
      @(posedge clk); #1;
      wr_addr_log.delete();
      wr_data_log.delete();
      w0 = wr_cnt;
      bus.flush_req = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) bus.flush_req = 1'b0;
         seen = bus.flush_done;
      end
      $display("flush: done=%0d after %0d cycles, writes=%0d", seen, n, wr_cnt - w0);
      n_cmp++;
      if (!seen || n !== 19) begin
         n_bad++;
         $display("FAIL flush_timing: done=%0d cycles=%0d, required 1 19", seen, n);
      end
      n_cmp++;
      if (wr_cnt - w0 !== 2 || wr_addr_log.size() != 2) begin
         n_bad++;
         $display("FAIL flush_writes: count=%0d, required 2", wr_cnt - w0);
      end else begin
         if (wr_addr_log[0] !== 32'h20 || wr_addr_log[1] !== 32'hF0 ||
             wr_data_log[0] !== 128'hA0A0A0A0_CAFEF00D_C2C2C2C2_D3D3D3D3 ||
             wr_data_log[1] !== 128'h0F0F0F0F_F2F2F2F2_F3F3F3F3_F4F4F4F4) begin
            n_bad++;
            $display("FAIL flush_data: a0=%08h a1=%08h d0=%032h d1=%032h, required 00000020 000000F0",
                     wr_addr_log[0], wr_addr_log[1], wr_data_log[0], wr_data_log[1]);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.mem_flush !== 1'b1 || bus.flush_done !== 1'b0 || bus.cpu_stall !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_after: mem_flush=%0d flush_done=%0d stall=%0d, required 1 0 0",
                  bus.mem_flush, bus.flush_done, bus.cpu_stall);
      end
   endtask

   task automatic test_reset_during_fill();
      int lat, rds, wrs; logic rd0; logic [WS-1:0] rdata, addr0;
      @(posedge clk); #1;
      bus.cpu_req = 1'b1;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = 32'h10;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.mem_readable !== 1'b1 || bus.mem_addr !== 32'h10) begin
         n_bad++;
         $display("FAIL rst_fill_entry: readable=%0d addr=%08h, required 1 00000010",
                  bus.mem_readable, bus.mem_addr);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.cpu_ready, bus.cpu_stall, bus.mem_readable, bus.mem_writable, bus.mem_flush,
           bus.flush_done} !== 6'b0 || bus.mem_addr !== '0) begin
         n_bad++;
         $display("FAIL rst_fill_outputs: ready=%0d stall=%0d rd=%0d wr=%0d mflush=%0d addr=%08h, required 0",
                  bus.cpu_ready, bus.cpu_stall, bus.mem_readable, bus.mem_writable,
                  bus.mem_flush, bus.mem_addr);
      end
      bus.cpu_req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset during fill released");
      access(1'b0, 32'h10, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 3 || rds !== 1 || rdata !== 32'h11111111) begin
         n_bad++;
         $display("FAIL rst_refetch: lat=%0d rd=%0d rdata=%08h, required 3 1 11111111",
                  lat, rds, rdata);
      end
      access(1'b0, 32'h24, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 3 || rdata !== 32'hCAFEF00D) begin
         n_bad++;
         $display("FAIL rst_invalidated: lat=%0d rdata=%08h, required 3 CAFEF00D", lat, rdata);
      end
   endtask

   task automatic test_priority();
      int lat, rds, wrs, n, w0; logic rd0, seen; logic [WS-1:0] rdata, addr0;
      bus.flush_req = 1'b1;
      access(1'b0, 32'h34, '0, lat, rdata, rds, wrs, rd0, addr0);
      n_cmp++;
      if (lat !== 3 || rdata !== 32'h00000030 || rd0 !== 1'b1 || addr0 !== 32'h30) begin
         n_bad++;
         $display("FAIL prio_cpu_first: lat=%0d rdata=%08h rd0=%0d addr=%08h, required 3 00000030 1 00000030",
                  lat, rdata, rd0, addr0);
      end
      w0 = wr_cnt;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (bus.cpu_stall) bus.flush_req = 1'b0;
         seen = bus.flush_done;
      end
      bus.flush_req = 1'b0;
      $display("prio flush: done=%0d after %0d cycles", seen, n);
      n_cmp++;
      if (!seen || n !== 18 || wr_cnt - w0 !== 0) begin
         n_bad++;
         $display("FAIL prio_flush: done=%0d cycles=%0d writes=%0d, required 1 18 0",
                  seen, n, wr_cnt - w0);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.mem_flush !== 1'b1 || both_cnt !== 0) begin
         n_bad++;
         $display("FAIL prio_end: mem_flush=%0d both_strobes=%0d, required 1 0",
                  bus.mem_flush, both_cnt);
      end
   endtask

   initial begin
      bus.cpu_req = 1'b0;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_wdata = '0;
      bus.flush_req = 1'b0;
      test_reset();
      test_load_miss_hit();
      test_store_hit();
      test_dirty_evict();
      test_store_miss();
      test_flush();
      test_reset_during_fill();
      test_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
